// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   // Widest operand the magnitude helper can carry.
   localparam int MAXW = 64;

   // Bits needed to count 0..n-1 (never less than one).
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Two's-complement magnitude of a sign-extended value when neg is set.
   function automatic logic [MAXW:0] abs_w(
      input logic [MAXW:0] v,
      input logic          neg
   );
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: adds |a| * (K multiplier bits) << shamt.
module mult_step
   import seq_mult_pkg::*;
#(
   parameter int W = 4,
   parameter int K = 1,
   localparam int AW = 2 * W + 1,
   localparam int SW = cnt_w(AW)
) (
   input  logic [AW-1:0] acc,
   input  logic [W:0]    a_mag,
   input  logic [K-1:0]  b_bits,
   input  logic [SW-1:0] shamt,
   output logic [AW-1:0] acc_next
);

   logic [AW-1:0] pp;

   always_comb begin
      pp       = AW'(a_mag) * AW'(b_bits);
      acc_next = acc + (pp << shamt);
   end

endmodule

// File: rtl/seq_mult.sv
// Iterative W x W multiplier retiring K multiplier bits per cycle,
// with signed/unsigned mode and valid/ready on both sides.
module seq_mult
   import seq_mult_pkg::*;
#(
   parameter int W = 4,
   parameter int K = 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   input  logic           signed_mode,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [2*W-1:0] z,
   output logic           busy
);

   localparam int STEPS = W / K;
   localparam int CW    = cnt_w(STEPS);
   localparam int AW    = 2 * W + 1;
   localparam int SW    = cnt_w(AW);
   localparam int MW    = MAXW + 1;

   generate
      if (W < 2 || K < 1 || K > W || (W % K) != 0 || W >= MAXW) begin : g_bad_cfg
         $error("seq_mult: illegal W/K combination");
      end
   endgenerate

   state_e         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [AW-1:0]  acc_q, acc_d;
   logic [AW-1:0]  acc_nx;
   logic [W:0]     a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic           neg_q, neg_d;
   logic [2*W-1:0] z_q, z_d;
   logic [SW-1:0]  shamt;
   logic           a_neg, b_neg;

   assign shamt = SW'(cnt_q) * SW'(K);

   mult_step #(
      .W(W),
      .K(K)
   ) u_step (
      .acc      (acc_q),
      .a_mag    (a_q),
      .b_bits   (b_q[K-1:0]),
      .shamt    (shamt),
      .acc_next (acc_nx)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      a_d     = a_q;
      b_d     = b_q;
      neg_d   = neg_q;
      z_d     = z_q;
      a_neg   = signed_mode & a[W-1];
      b_neg   = signed_mode & b[W-1];
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               // |b| never needs bit W: the largest signed magnitude is 2^(W-1).
               a_d     = (W+1)'(abs_w(MW'({a_neg, a}), a_neg));
               b_d     = W'(abs_w(MW'({b_neg, b}), b_neg));
               neg_d   = a_neg ^ b_neg;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            acc_d = acc_nx;
            cnt_d = cnt_q + CW'(1);
            b_d   = b_q >> K;
            if (cnt_q == CW'(STEPS - 1)) begin
               z_d     = (2*W)'(neg_q ? -acc_nx : acc_nx);
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         neg_q   <= 1'b0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         neg_q   <= neg_d;
         z_q     <= z_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q == BUSY);
   assign out_valid = (state_q == DONE);
   assign z         = z_q;

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult: four configurations against a cycle-level
// latency/product model, plus directed literal expectations.
module tb_seq_mult;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       iv[4], smv[4], ors[4], stall[4], rnd[4], orv[4];
   logic [7:0] av[4], bv[4];
   logic       ir[4], ov[4], bz[4];
   logic [7:0]  z0, z1, z2;
   logic [15:0] z3;

   int total  = 0;
   int passed = 0;
   int nfail  = 0;
   bit chk_on = 1'b0;

   int          mph[4], mcnt[4];
   logic [15:0] mz[4], pend[4];

   always #5 clk = ~clk;

   seq_mult #(.W(4), .K(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
      .a(av[0][3:0]), .b(bv[0][3:0]), .signed_mode(smv[0]),
      .out_valid(ov[0]), .out_ready(orv[0]), .z(z0), .busy(bz[0]));

   seq_mult #(.W(4), .K(2)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
      .a(av[1][3:0]), .b(bv[1][3:0]), .signed_mode(smv[1]),
      .out_valid(ov[1]), .out_ready(orv[1]), .z(z1), .busy(bz[1]));

   seq_mult #(.W(4), .K(4)) u2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
      .a(av[2][3:0]), .b(bv[2][3:0]), .signed_mode(smv[2]),
      .out_valid(ov[2]), .out_ready(orv[2]), .z(z2), .busy(bz[2]));

   seq_mult #(.W(8), .K(2)) u3 (
      .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]),
      .a(av[3]), .b(bv[3]), .signed_mode(smv[3]),
      .out_valid(ov[3]), .out_ready(orv[3]), .z(z3), .busy(bz[3]));

   function automatic int wof(int i);
      return (i == 3) ? 8 : 4;
   endfunction

   function automatic int stp(int i);
      case (i)
         0: return 4;
         1: return 2;
         2: return 1;
         default: return 4;
      endcase
   endfunction

   function automatic logic [15:0] zget(int i);
      case (i)
         0: return {8'h00, z0};
         1: return {8'h00, z1};
         2: return {8'h00, z2};
         default: return z3;
      endcase
   endfunction

   // Reference product: interpret operands at width w, multiply, keep 2w bits.
   function automatic logic [15:0] prod(int w, logic [7:0] x, logic [7:0] y, logic s);
      longint m, xs, ys;
      m  = (longint'(1) << w) - 1;
      xs = longint'(x) & m;
      ys = longint'(y) & m;
      if (s) begin
         if (((xs >> (w - 1)) & 1) != 0) xs = xs - (longint'(1) << w);
         if (((ys >> (w - 1)) & 1) != 0) ys = ys - (longint'(1) << w);
      end
      return 16'((xs * ys) & ((longint'(1) << (2 * w)) - 1));
   endfunction

   task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
      total++;
      if (act === exp) passed++;
      else begin
         nfail++;
         if (nfail <= 20) $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Model: accept in idle, result visible STEPS edges later, held until taken.
   always @(posedge clk or posedge rst) begin
      for (int i = 0; i < 4; i++) begin
         if (rst) begin
            mph[i]  <= 0;
            mcnt[i] <= 0;
            mz[i]   <= '0;
         end else if (mph[i] == 0) begin
            if (iv[i]) begin
               mph[i]  <= 1;
               mcnt[i] <= 1;
               pend[i] <= prod(wof(i), av[i], bv[i], smv[i]);
            end
         end else if (mph[i] == 1) begin
            if (mcnt[i] == stp(i)) begin
               mph[i] <= 2;
               mz[i]  <= pend[i];
            end else begin
               mcnt[i] <= mcnt[i] + 1;
            end
         end else if (orv[i]) begin
            mph[i] <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && chk_on) begin
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("ctl%0d", i), 16'({ir[i], bz[i], ov[i]}),
                16'({mph[i] == 0, mph[i] == 1, mph[i] == 2}));
            chk($sformatf("z%0d", i), zget(i), mz[i]);
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) rnd[i] <= 1'($urandom_range(0, 1));
   end

   always_comb begin
      for (int i = 0; i < 4; i++) orv[i] = stall[i] ? rnd[i] : ors[i];
   end

   task automatic start(int i, logic [7:0] a, logic [7:0] b, logic s);
      int n;
      n = 0;
      while (!ir[i] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("idle_timeout", 16'(ir[i]), 16'd1);
      iv[i]  = 1'b1;
      av[i]  = a;
      bv[i]  = b;
      smv[i] = s;
      @(negedge clk);
      iv[i] = 1'b0;
   endtask

   task automatic wait_ov(int i, output int cyc);
      cyc = 0;
      while (!ov[i] && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 100) chk("ov_timeout", 16'(ov[i]), 16'd1);
   endtask

   task automatic finish_op(int i);
      int n;
      n = 0;
      while (ov[i] && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("drain_timeout", 16'(ov[i]), 16'd0);
   endtask

   task automatic op(int i, logic [7:0] a, logic [7:0] b, logic s,
                     output logic [15:0] zr, output int lat);
      start(i, a, b, s);
      wait_ov(i, lat);
      zr = zget(i);
      finish_op(i);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] zr;
      int lat;
      for (int i = 0; i < 4; i++) begin
         iv[i] = 1'b0; av[i] = '0; bv[i] = '0; smv[i] = 1'b0;
         ors[i] = 1'b1; stall[i] = 1'b0;
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ready", 16'(ir[0]), 16'd1);
      chk("rst_ov", 16'(ov[0]), 16'd0);
      chk("rst_busy", 16'(bz[0]), 16'd0);
      chk("rst_z", zget(0), 16'h0000);
      rst = 1'b0;
      chk_on = 1'b1;

      op(0, 8'd15, 8'd15, 1'b0, zr, lat);
      chk("u15x15", zr, 16'h00E1);
      chk("lat_k1", 16'(lat), 16'd4);
      chk("idle_after", 16'(ir[0]), 16'd1);

      op(0, 8'h08, 8'h08, 1'b1, zr, lat);
      chk("s_min_sq", zr, 16'h0040);
      op(0, 8'h0D, 8'h05, 1'b1, zr, lat);
      chk("s_m3x5", zr, 16'h00F1);
      op(0, 8'h07, 8'h0F, 1'b1, zr, lat);
      chk("s_7xm1", zr, 16'h00F9);

      // Backpressure with ignored operands during the stall.
      ors[0] = 1'b0;
      start(0, 8'd9, 8'd6, 1'b0);
      wait_ov(0, lat);
      chk("bp_z", zget(0), 16'h0036);
      for (int k = 0; k < 5; k++) begin
         iv[0] = 1'b1; av[0] = 8'd1; bv[0] = 8'd1;
         @(negedge clk);
         chk("bp_hold_ov", 16'(ov[0]), 16'd1);
         chk("bp_hold_z", zget(0), 16'h0036);
         chk("bp_hold_rdy", 16'(ir[0]), 16'd0);
      end
      iv[0] = 1'b0;
      ors[0] = 1'b1;
      @(negedge clk);
      chk("bp_release_ov", 16'(ov[0]), 16'd0);
      chk("bp_release_rdy", 16'(ir[0]), 16'd1);

      // Asynchronous abort in the second busy cycle.
      start(0, 8'd3, 8'd5, 1'b0);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("ar_ov", 16'(ov[0]), 16'd0);
      chk("ar_z", zget(0), 16'h0000);
      chk("ar_rdy", 16'(ir[0]), 16'd1);
      chk("ar_busy", 16'(bz[0]), 16'd0);
      @(negedge clk);
      rst = 1'b0;
      op(0, 8'd2, 8'd2, 1'b0, zr, lat);
      chk("post_rst", zr, 16'h0004);

      op(3, 8'hFF, 8'hFF, 1'b0, zr, lat);
      chk("w8_u255sq", zr, 16'hFE01);
      chk("lat_w8k2", 16'(lat), 16'd4);
      op(3, 8'h80, 8'h7F, 1'b1, zr, lat);
      chk("w8_sm128x127", zr, 16'hC080);
      op(2, 8'h0F, 8'h0F, 1'b1, zr, lat);
      chk("k4_m1xm1", zr, 16'h0001);
      chk("lat_k4", 16'(lat), 16'd1);
      op(1, 8'h08, 8'h07, 1'b1, zr, lat);
      chk("k2_m8x7", zr, 16'h00C8);
      chk("lat_k2", 16'(lat), 16'd2);

      for (int i = 0; i < 3; i++) begin
         stall[i] = 1'b1;
         for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 16; x++) begin
               for (int y = 0; y < 16; y++) begin
                  op(i, 8'(x), 8'(y), 1'(s), zr, lat);
                  chk($sformatf("exh%0d_%0d_%0dx%0d", i, s, x, y), zr,
                      prod(4, 8'(x), 8'(y), 1'(s)));
               end
            end
         end
         stall[i] = 1'b0;
         @(negedge clk);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/seq_mult.md
Name: seq_mult

Overview:
- Parametrised, iterative shift-add multiplier; successor to the fixed 4x4 combinational multiplier.
- Generalised in operand width (W) and bits retired per cycle (K).
- Adds a signed/unsigned mode and valid/ready handshakes on both input and output.
- Sits between an operand producer and a result consumer; trades area for latency of W/K cycles.

Parameters:
- W, 4, operand width in bits; product is 2W bits; W >= 2.
- K, 1, multiplier bits retired per cycle; 1 <= K <= W; W mod K == 0 (elaboration-time assertion).

Ports:
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- in_valid  in  1  operands a, b, signed_mode are valid.
- in_ready  out  1  block can accept operands.
- a  in  W  multiplicand.
- b  in  W  multiplier.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with operands.
- out_valid  out  1  z holds a completed product.
- out_ready  in  1  consumer accepts z.
- z  out  2W  product.
- busy  out  1  high while in BUSY state.

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0, z=0, internal accumulator/counter=0.
- FSM states: IDLE, BUSY, DONE. STEPS = W/K.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: capture |a| and |b|, capture result sign (signed_mode & (a[W-1]^b[W-1])), clear accumulator and step counter, go to BUSY.
  - Unsigned mode: magnitude = raw value.
  - Signed mode: magnitude = two's-complement absolute value, W+1-bit internally so that -2^(W-1) is represented correctly.
- BUSY:
  - in_ready=0, busy=1.
  - Each edge: accumulator += |a| * (next K LSBs of |b|) << (K*step); step++.
  - On the edge completing step STEPS-1: register z = sign ? -acc : acc (truncated to 2W), set out_valid=1, go to DONE.
- DONE:
  - out_valid=1; z and out_valid held stable until out_valid&&out_ready.
  - On that edge: out_valid=0, go to IDLE. z retains its last value (not cleared).
- Latency: out_valid rises exactly STEPS clocks after the accepting edge. Throughput: one product per STEPS+2 cycles minimum (in_ready only in IDLE).
- Width rules: all arithmetic internally 2W+1 bits; result truncated to 2W. Signed (-2^(W-1))^2 = 2^(2W-2) fits.
- Inputs a, b, signed_mode are ignored when in_ready=0; changes during BUSY have no effect.
- out_ready is ignored outside DONE.
- rst asserted in any state (incl. mid-BUSY or stalled DONE): immediate abort to reset values; no partial result emitted.
- Multiplication by 0: still takes STEPS cycles (no early termination), z=0.

Decomposition:
- Package seq_mult_pkg:
  - state enum {IDLE, BUSY, DONE};
  - function clog2-based counter width;
  - function abs_w (two's-complement magnitude with mode select).
- One sub-module mult_step: combinational, takes accumulator, |a|, K multiplier bits and shift amount; returns next accumulator. Instantiated once; FSM, counter and handshakes stay in seq_mult.

Test Plan:
- W=4,K=1, unsigned a=15,b=15, out_ready=1 -> out_valid 4 cycles after accept, z=8'hE1; back in IDLE next cycle.
- W=4,K=1, signed a=4'b1000,b=4'b1000 -> z=8'h40; a=4'b1101(-3),b=5 -> z=8'hF1(-15); a=7,b=-1 -> z=8'hF9.
- Backpressure: W=4, a=9,b=6 unsigned, out_ready=0 for 5 cycles after out_valid -> z=8'h36 stable, out_valid held, in_ready=0, new in_valid ignored; out_ready=1 -> handshake, IDLE.
- Reset mid-op: accept a=3,b=5, assert rst on 2nd BUSY cycle -> out_valid=0, z=0, in_ready=1 asynchronously; next op a=2,b=2 -> z=4.
- W=8,K=2: unsigned 255*255 -> z=16'hFE01 after 4 cycles; signed -128*127 -> z=16'hC080.
- Exhaustive W=4,K in {1,2,4}: all 256 pairs in both modes against a behavioural product model, random out_ready stalls; zero mismatches.
